// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out bit serializer.
package serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Counter width that stays legal (>= 1 bit) even for single-bit words.
   function automatic int clog2_min1(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Holds the not-yet-sent bits of the current word; q_bit is the next bit to go out.
module piso_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             q_bit
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // The first bit of a loaded word goes straight to the output register, so
   // the stored copy is pre-advanced by one position on load.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] x);
      return MSB_FIRST ? (x << 1) : (x >> 1);
   endfunction

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = advance(d);
      end else if (shift) begin
         sr_d = advance(sr_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_bit_serializer.sv
// Word-in, bit-out serializer with valid/ready input and gapless word chaining.
// Handshake: a word transfers on a rising edge where in_valid & in_ready; in_valid may drop freely.
module piso_bit_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             busy
);

   localparam int              CNT_W    = clog2_min1(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   ser_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bit_q, bit_d;
   logic             valid_q, valid_d;
   logic             load;
   logic             shift;
   logic             first_bit;
   logic             sr_bit;

   // Ready on the last bit too, so the next word chains with no bubble.
   assign in_ready  = !reset && ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0)));
   assign load      = in_valid && in_ready;
   assign first_bit = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      valid_d = valid_q;
      shift   = 1'b0;
      if (load) begin
         state_d = SHIFT;
         cnt_d   = CNT_LAST;
         bit_d   = first_bit;
         valid_d = 1'b1;
      end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
         cnt_d   = cnt_q - CNT_W'(1);
         bit_d   = sr_bit;
         valid_d = 1'b1;
         shift   = 1'b1;
      end else begin
         state_d = IDLE;
         cnt_d   = '0;
         bit_d   = IDLE_BIT;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= IDLE_BIT;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         valid_q <= valid_d;
      end
   end

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_reg (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .shift (shift),
      .d     (in_data),
      .q_bit (sr_bit)
   );

   assign bit_out   = bit_q;
   assign bit_valid = valid_q;
   assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: MSB-first, LSB-first and single-bit instances share clk/reset.
module tb_piso_bit_serializer;

   logic clk;
   logic reset;

   int checks = 0;
   int errors = 0;

   // MSB-first, WIDTH=8
   logic [7:0] m_in_data;
   logic       m_in_valid, m_in_ready, m_bit_out, m_bit_valid, m_busy;
   // LSB-first, WIDTH=8
   logic [7:0] l_in_data;
   logic       l_in_valid, l_in_ready, l_bit_out, l_bit_valid, l_busy;
   // WIDTH=1
   logic [0:0] w_in_data;
   logic       w_in_valid, w_in_ready, w_bit_out, w_bit_valid, w_busy;

   logic [0:0] msb_q[$];
   logic [0:0] lsb_q[$];
   logic [0:0] w1_q[$];

   int run_len[3];
   int last_run[3];
   int ones_run;
   int y_cnt;

   piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk(clk), .reset(reset), .in_data(m_in_data), .in_valid(m_in_valid),
      .in_ready(m_in_ready), .bit_out(m_bit_out), .bit_valid(m_bit_valid), .busy(m_busy));

   piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .in_data(l_in_data), .in_valid(l_in_valid),
      .in_ready(l_in_ready), .bit_out(l_bit_out), .bit_valid(l_bit_valid), .busy(l_busy));

   piso_bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
      .clk(clk), .reset(reset), .in_data(w_in_data), .in_valid(w_in_valid),
      .in_ready(w_in_ready), .bit_out(w_bit_out), .bit_valid(w_bit_valid), .busy(w_busy));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (!reset) begin
         check("msb_busy_vs_valid", {31'd0, m_busy}, {31'd0, m_bit_valid});
         if (m_bit_valid) begin
            if (msb_q.size() == 0) begin
               check("msb_unexpected_bit", 32'd1, 32'd0);
            end else begin
               check("msb_bit", {31'd0, m_bit_out}, {31'd0, msb_q.pop_front()});
            end
            run_len[0]++;
            if (m_bit_out) begin
               ones_run++;
               if (ones_run >= 3) y_cnt++;
            end else begin
               ones_run = 0;
            end
         end else begin
            check("msb_idle_bit", {31'd0, m_bit_out}, 32'd0);
            if (run_len[0] != 0) last_run[0] = run_len[0];
            run_len[0] = 0;
            ones_run   = 0;
         end
      end else begin
         if (run_len[0] != 0) last_run[0] = run_len[0];
         run_len[0] = 0;
         ones_run   = 0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (l_bit_valid) begin
            if (lsb_q.size() == 0) check("lsb_unexpected_bit", 32'd1, 32'd0);
            else check("lsb_bit", {31'd0, l_bit_out}, {31'd0, lsb_q.pop_front()});
            run_len[1]++;
         end else begin
            check("lsb_idle_bit", {31'd0, l_bit_out}, 32'd0);
            if (run_len[1] != 0) last_run[1] = run_len[1];
            run_len[1] = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (w_bit_valid) begin
            if (w1_q.size() == 0) check("w1_unexpected_bit", 32'd1, 32'd0);
            else check("w1_bit", {31'd0, w_bit_out}, {31'd0, w1_q.pop_front()});
            run_len[2]++;
         end else begin
            check("w1_idle_bit", {31'd0, w_bit_out}, 32'd0);
            if (run_len[2] != 0) last_run[2] = run_len[2];
            run_len[2] = 0;
         end
      end
   end

   // ---------------- drivers ----------------
   // Call just after a rising edge; returns just after the transfer edge.
   task automatic send_msb(input logic [7:0] w, input bit hold, output int waits);
      m_in_data  = w;
      m_in_valid = 1'b1;
      waits      = 0;
      @(negedge clk);
      while (!m_in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!m_in_ready) begin
         check("msb_ready_timeout", 32'd0, 32'd1);
      end else begin
         for (int i = 7; i >= 0; i--) msb_q.push_back(w[i]);
      end
      @(posedge clk);
      #1;
      if (!hold) m_in_valid = 1'b0;
   endtask

   task automatic send_lsb(input logic [7:0] w);
      int waits;
      l_in_data  = w;
      l_in_valid = 1'b1;
      waits      = 0;
      @(negedge clk);
      while (!l_in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!l_in_ready) begin
         check("lsb_ready_timeout", 32'd0, 32'd1);
      end else begin
         for (int i = 0; i < 8; i++) lsb_q.push_back(w[i]);
      end
      @(posedge clk);
      #1;
      l_in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   logic [0:0] w1_pat[5];
   int waits;

   initial begin
      reset      = 1'b1;
      m_in_data  = '0; m_in_valid = 1'b0;
      l_in_data  = '0; l_in_valid = 1'b0;
      w_in_data  = '0; w_in_valid = 1'b0;
      run_len    = '{0, 0, 0};
      last_run   = '{0, 0, 0};
      ones_run   = 0;
      y_cnt      = 0;
      w1_pat     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

      // Reset values
      @(negedge clk);
      check("rst_bit_out",   {31'd0, m_bit_out},   32'd0);
      check("rst_bit_valid", {31'd0, m_bit_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, m_in_ready},  32'd0);
      check("rst_busy",      {31'd0, m_busy},      32'd0);
      check("rst_w1_ready",  {31'd0, w_in_ready},  32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, m_in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // 1: single MSB-first word, ready profile and two 111 detections
      send_msb(8'b0111_0111, 1'b0, waits);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t1_in_ready", {31'd0, m_in_ready}, (i == 7) ? 32'd1 : 32'd0);
      end
      idle_cycles(3);
      check("t1_run_len", last_run[0], 32'd8);
      check("t1_y_count", y_cnt, 32'd2);

      // 2: back-to-back FF then 00, no bubble
      send_msb(8'hFF, 1'b1, waits);
      send_msb(8'h00, 1'b0, waits);
      check("t2_ready_wait", waits, 32'd7);
      idle_cycles(10);
      check("t2_run_len", last_run[0], 32'd16);

      // 3: LSB-first 01
      send_lsb(8'h01);
      idle_cycles(10);
      check("t3_run_len", last_run[1], 32'd8);

      // 4: reset after three bits of AA, then F0 whole
      send_msb(8'hAA, 1'b0, waits);
      for (int i = 0; i < 3; i++) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      msb_q.delete();
      check("t4_async_bit_out",   {31'd0, m_bit_out},   32'd0);
      check("t4_async_bit_valid", {31'd0, m_bit_valid}, 32'd0);
      check("t4_async_ready",     {31'd0, m_in_ready},  32'd0);
      check("t4_async_busy",      {31'd0, m_busy},      32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      check("t4_ready_after", {31'd0, m_in_ready}, 32'd1);
      check("t4_aborted_run", last_run[0], 32'd3);
      @(posedge clk);
      #1;
      send_msb(8'hF0, 1'b0, waits);
      check("t4_no_wait", waits, 32'd0);
      idle_cycles(10);
      check("t4_run_len", last_run[0], 32'd8);

      // 5: held valid while busy: one transfer per word, taken on the last-bit edge
      send_msb(8'hA5, 1'b1, waits);
      send_msb(8'h3C, 1'b1, waits);
      check("t5_ready_wait", waits, 32'd7);
      send_msb(8'hC3, 1'b0, waits);
      check("t5_ready_wait2", waits, 32'd7);
      idle_cycles(10);
      check("t5_run_len", last_run[0], 32'd24);

      // 6: WIDTH=1 streaming
      for (int i = 0; i < 5; i++) begin
         w_in_data  = w1_pat[i];
         w_in_valid = 1'b1;
         @(negedge clk);
         check("t6_w1_ready", {31'd0, w_in_ready}, 32'd1);
         w1_q.push_back(w1_pat[i]);
         @(posedge clk);
         #1;
      end
      w_in_valid = 1'b0;
      idle_cycles(4);
      check("t6_run_len", last_run[2], 32'd5);

      check("msb_q_drained", msb_q.size(), 32'd0);
      check("lsb_q_drained", lsb_q.size(), 32'd0);
      check("w1_q_drained",  w1_q.size(),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Overall time limit so the bench always terminates.
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
